// File: rtl/keypad_matrix_scanner_if.sv
// Keypad scanner signal bundle: row inputs from the keypad pins, column
// strobes back to the pins, and the decoded key outputs towards the consumer.
interface keypad_matrix_scanner_if #(
    parameter int N_ROWS = 4,
    parameter int N_COLS = 3,
    parameter int CODE_W = $clog2(N_ROWS * N_COLS)
);
    logic [N_ROWS-1:0] row;
    logic [N_COLS-1:0] col;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_held;
    logic              multi_key;

    // scanner side
    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held,
        output multi_key
    );

    // keypad / key-consumer side
    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  multi_key
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// Parametrised keypad matrix scanner. Strobes one column at a time, samples
// synchronised rows once per scan tick, debounces press and release, and
// reports the pressed key as row_idx*N_COLS+col_idx with a one-clock strobe.
module keypad_matrix_scanner #(
    parameter int N_ROWS   = 4,
    parameter int N_COLS   = 3,
    parameter int SCAN_DIV = 2700,
    parameter int DEBOUNCE = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    keypad_matrix_scanner_if.master bus
);
    localparam int   CODE_W  = $clog2(N_ROWS * N_COLS);
    localparam int   PRE_W   = $clog2(SCAN_DIV);
    localparam int   CI_W    = $clog2(N_COLS);
    localparam int   RI_W    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int   DC_W    = $clog2(DEBOUNCE + 1);
    localparam logic DEB_ONE = (DEBOUNCE == 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Index of the lowest set row bit (0 when none are set).
    function automatic logic [RI_W-1:0] lowest_row(input logic [N_ROWS-1:0] v);
        logic [RI_W-1:0] idx;
        idx = {RI_W{1'b0}};
        for (int i = N_ROWS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = RI_W'(i);
            end
        end
        return idx;
    endfunction

    // One-hot column strobe for a column index.
    function automatic logic [N_COLS-1:0] col_onehot(input logic [CI_W-1:0] idx);
        logic [N_COLS-1:0] v;
        v      = {N_COLS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [N_ROWS-1:0] sync1_r;
    logic [N_ROWS-1:0] sync2_r;
    logic [PRE_W-1:0]  presc_r;
    state_t            state_r;
    logic [CI_W-1:0]   col_idx_r;
    logic [N_COLS-1:0] col_r;
    logic [N_ROWS-1:0] lrow_r;
    logic [DC_W-1:0]   deb_cnt_r;
    logic [CODE_W-1:0] key_code_r;
    logic              key_valid_r;
    logic              key_held_r;
    logic              multi_key_r;

    logic [N_ROWS-1:0] row_s;
    logic              tick_s;
    logic              row_zero_s;
    logic              multi_s;
    logic [CI_W-1:0]   nxt_col_s;
    logic [DC_W-1:0]   deb_next_s;
    logic [CODE_W-1:0] code_s;
    logic              press_accept_s;
    logic              release_done_s;

    assign row_s      = sync2_r;
    assign tick_s     = (presc_r == PRE_W'(SCAN_DIV - 1));
    assign row_zero_s = (row_s == {N_ROWS{1'b0}});
    assign multi_s    = |(row_s & (row_s - N_ROWS'(1)));
    assign nxt_col_s  = (col_idx_r == CI_W'(N_COLS - 1)) ? {CI_W{1'b0}} : col_idx_r + CI_W'(1);
    assign deb_next_s = deb_cnt_r + DC_W'(1);
    assign code_s     = CODE_W'(int'(lowest_row(row_s)) * N_COLS + int'(col_idx_r));

    // A press is accepted on the tick where the stable count reaches DEBOUNCE;
    // with DEBOUNCE==1 the detecting tick itself is the accepting one.
    assign press_accept_s = tick_s && !row_zero_s &&
                            (((state_r == ST_SCAN) && DEB_ONE) ||
                             ((state_r == ST_DEBOUNCE) && (row_s == lrow_r) &&
                              (deb_next_s == DC_W'(DEBOUNCE))));

    // Same counting rule for the release side.
    assign release_done_s = tick_s && row_zero_s &&
                            (((state_r == ST_PRESSED) && DEB_ONE) ||
                             ((state_r == ST_RELEASE) && (deb_next_s == DC_W'(DEBOUNCE))));

    assign bus.col       = col_r;
    assign bus.key_code  = key_code_r;
    assign bus.key_valid = key_valid_r;
    assign bus.key_held  = key_held_r;
    assign bus.multi_key = multi_key_r;

    // Two-flop synchroniser for the asynchronous row lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= {N_ROWS{1'b0}};
            sync2_r <= {N_ROWS{1'b0}};
        end else begin
            sync1_r <= bus.row;
            sync2_r <= sync1_r;
        end
    end

    // Scan prescaler: wraps every SCAN_DIV clocks, tick on the last count.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= {PRE_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PRE_W{1'b0}};
        end else begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    // Scan/debounce FSM with registered column strobe and key outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_SCAN;
            col_idx_r   <= {CI_W{1'b0}};
            col_r       <= col_onehot({CI_W{1'b0}});
            lrow_r      <= {N_ROWS{1'b0}};
            deb_cnt_r   <= {DC_W{1'b0}};
            key_code_r  <= {CODE_W{1'b0}};
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            multi_key_r <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            if (press_accept_s) begin
                lrow_r    <= row_s;
                deb_cnt_r <= {DC_W{1'b0}};
                if (multi_s) begin
                    // ambiguous press: flag it, report nothing, wait for release
                    multi_key_r <= 1'b1;
                    state_r     <= ST_RELEASE;
                end else begin
                    key_code_r  <= code_s;
                    key_valid_r <= 1'b1;
                    key_held_r  <= 1'b1;
                    state_r     <= ST_PRESSED;
                end
            end else if (release_done_s) begin
                key_held_r  <= 1'b0;
                multi_key_r <= 1'b0;
                deb_cnt_r   <= {DC_W{1'b0}};
                col_idx_r   <= nxt_col_s;
                col_r       <= col_onehot(nxt_col_s);
                state_r     <= ST_SCAN;
            end else if (tick_s) begin
                case (state_r)
                    ST_SCAN: begin
                        if (row_zero_s) begin
                            col_idx_r <= nxt_col_s;
                            col_r     <= col_onehot(nxt_col_s);
                        end else begin
                            lrow_r    <= row_s;
                            deb_cnt_r <= DC_W'(1);
                            state_r   <= ST_DEBOUNCE;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (row_s == lrow_r) begin
                            deb_cnt_r <= deb_next_s;
                        end else begin
                            // bounce: give up on this column and keep scanning
                            deb_cnt_r <= {DC_W{1'b0}};
                            col_idx_r <= nxt_col_s;
                            col_r     <= col_onehot(nxt_col_s);
                            state_r   <= ST_SCAN;
                        end
                    end
                    ST_PRESSED: begin
                        if (row_zero_s) begin
                            deb_cnt_r <= DC_W'(1);
                            state_r   <= ST_RELEASE;
                        end else if (row_s != lrow_r) begin
                            multi_key_r <= 1'b1;
                        end else begin
                            multi_key_r <= multi_key_r;
                        end
                    end
                    ST_RELEASE: begin
                        if (row_zero_s) begin
                            deb_cnt_r <= deb_next_s;
                        end else begin
                            // release bounce: back to held, no new key_valid
                            deb_cnt_r <= {DC_W{1'b0}};
                            state_r   <= ST_PRESSED;
                        end
                    end
                    default: begin
                        state_r <= ST_SCAN;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: keypad physics model (pressed switches
// connect a row to the strobed column), directed vector table, hand-written
// corner sequences, and random presses/bounces/resets against a tick-level
// reference model.
module tb_keypad_matrix_scanner;
    localparam int N_ROWS   = 4;
    localparam int N_COLS   = 3;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int N_KEYS   = N_ROWS * N_COLS;

    localparam int M_IDLE    = 0;
    localparam int M_CONFIRM = 1;
    localparam int M_HOLD    = 2;
    localparam int M_REL     = 3;

    logic clk;
    logic reset;
    logic [N_KEYS-1:0] pressed;
    logic              ovr_en;
    logic [N_ROWS-1:0] ovr_row;
    logic [N_ROWS-1:0] keys_row;
    logic              chk_en;

    int n_chk;
    int n_fail;
    int vcount;

    keypad_matrix_scanner_if #(.N_ROWS(N_ROWS), .N_COLS(N_COLS)) kp_if ();

    keypad_matrix_scanner #(
        .N_ROWS  (N_ROWS),
        .N_COLS  (N_COLS),
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (kp_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad physics: a closed switch at (r,c) drives row r while column c is strobed.
    always_comb begin
        keys_row = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLS; c++) begin
                if (pressed[r*N_COLS+c] && kp_if.col[c]) keys_row[r] = 1'b1;
            end
        end
    end
    assign kp_if.row = ovr_en ? ovr_row : keys_row;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one step per clock) ----------------
    int          m_pre, m_col, m_mode, m_cnt, m_code;
    logic [3:0]  m_lrow, h0, h1;
    bit          m_valid, m_held, m_multi;

    function automatic int low_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic m_clear();
        m_pre = 0; m_col = 0; m_mode = M_IDLE; m_cnt = 0; m_code = 0;
        m_lrow = '0; h0 = '0; h1 = '0;
        m_valid = 0; m_held = 0; m_multi = 0;
    endtask

    task automatic m_accept(input logic [3:0] rs);
        m_lrow = rs;
        m_cnt  = 0;
        if ($countones(rs) > 1) begin
            m_multi = 1;
            m_mode  = M_REL;
        end else begin
            m_code  = low_idx(rs) * N_COLS + m_col;
            m_valid = 1;
            m_held  = 1;
            m_mode  = M_HOLD;
        end
    endtask

    task automatic m_released();
        m_held = 0; m_multi = 0; m_cnt = 0;
        m_col  = (m_col + 1) % N_COLS;
        m_mode = M_IDLE;
    endtask

    task automatic m_tick(input logic [3:0] rs);
        case (m_mode)
            M_IDLE: begin
                if (rs == 0) m_col = (m_col + 1) % N_COLS;
                else begin
                    m_lrow = rs; m_cnt = 1; m_mode = M_CONFIRM;
                    if (m_cnt >= DEBOUNCE) m_accept(rs);
                end
            end
            M_CONFIRM: begin
                if (rs == m_lrow) begin
                    m_cnt++;
                    if (m_cnt >= DEBOUNCE) m_accept(rs);
                end else begin
                    m_cnt = 0; m_col = (m_col + 1) % N_COLS; m_mode = M_IDLE;
                end
            end
            M_HOLD: begin
                if (rs == 0) begin
                    m_cnt = 1; m_mode = M_REL;
                    if (m_cnt >= DEBOUNCE) m_released();
                end else if (rs != m_lrow) m_multi = 1;
            end
            default: begin
                if (rs == 0) begin
                    m_cnt++;
                    if (m_cnt >= DEBOUNCE) m_released();
                end else begin
                    m_cnt = 0; m_mode = M_HOLD;
                end
            end
        endcase
    endtask

    initial begin
        logic [3:0] rs;
        m_clear();
        forever begin
            @(posedge clk);
            if (reset) m_clear();
            else begin
                rs = h1; h1 = h0; h0 = kp_if.row;
                m_valid = 0;
                if (m_pre == SCAN_DIV - 1) begin
                    m_pre = 0;
                    m_tick(rs);
                end else m_pre++;
            end
        end
    end

    // Compare every DUT output against the model away from the active edge.
    initial begin
        logic [2:0] ecol;
        forever begin
            @(negedge clk);
            if (kp_if.key_valid) vcount++;
            if (chk_en) begin
                ecol = 3'b001 << m_col;
                chk("model", {kp_if.col, kp_if.key_code, kp_if.key_valid, kp_if.key_held, kp_if.multi_key},
                    {ecol, 4'(m_code), m_valid, m_held, m_multi});
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        int         scen;
        int         cyc;
        logic [2:0] col;
        logic [3:0] code;
        logic       valid;
        logic       held;
        logic       multi;
    } vec_t;

    vec_t vecs[$];
    logic [N_KEYS-1:0] scen_keys[3];
    int                scen_rel[3];
    int                scen_nvalid[3];

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        pressed = '0;
        ovr_en  = 1'b0;
        ovr_row = '0;
        chk_en  = 1'b0;
        n_chk   = 0;
        n_fail  = 0;
        vcount  = 0;

        // scenario 0: idle scan, 1: single key (1,1), 2: two keys in column 0
        scen_keys   = '{12'h000, 12'h010, 12'h041};
        scen_rel    = '{0, 40, 30};
        scen_nvalid = '{0, 1, 0};
        vecs.push_back('{0,  1, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0,  3, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0,  4, 3'b010, 4'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0,  7, 3'b010, 4'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0,  8, 3'b100, 4'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 12, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 16, 3'b010, 4'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 24, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1,  3, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 15, 3'b010, 4'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 16, 3'b010, 4'd4, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1, 17, 3'b010, 4'd4, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1, 51, 3'b010, 4'd4, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1, 52, 3'b100, 4'd4, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 56, 3'b001, 4'd4, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2, 11, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2, 12, 3'b001, 4'd0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{2, 43, 3'b001, 4'd0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{2, 44, 3'b010, 4'd0, 1'b0, 1'b0, 1'b0});

        // reset values while reset is held
        repeat (3) @(negedge clk);
        chk("reset_state", {kp_if.col, kp_if.key_code, kp_if.key_valid, kp_if.key_held, kp_if.multi_key},
            {3'b001, 4'd0, 1'b0, 1'b0, 1'b0});
        reset  = 1'b0;
        chk_en = 1'b1;

        for (int s = 0; s < 3; s++) begin
            pressed = scen_keys[s];
            do_reset(3);
            vcount = 0;
            for (int n = 1; n <= 60; n++) begin
                @(negedge clk);
                foreach (vecs[i]) begin
                    if (vecs[i].scen == s && vecs[i].cyc == n)
                        chk($sformatf("vec s%0d c%0d", s, n),
                            {kp_if.col, kp_if.key_code, kp_if.key_valid, kp_if.key_held, kp_if.multi_key},
                            {vecs[i].col, vecs[i].code, vecs[i].valid, vecs[i].held, vecs[i].multi});
                end
                if (n == scen_rel[s]) pressed = '0;
            end
            chk($sformatf("valid_count s%0d", s), vcount, scen_nvalid[s]);
        end

        // bounce: row seen on one tick only, gone on the next
        pressed = '0;
        do_reset(3);
        vcount = 0;
        begin
            int waited;
            waited = 0;
            while (kp_if.col != 3'b010 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            chk("bounce_wait_col", {31'd0, kp_if.col == 3'b010}, 32'd1);
        end
        ovr_row = 4'b0010;
        ovr_en  = 1'b1;
        repeat (4) @(negedge clk);
        chk("bounce_col_frozen", kp_if.col, 3'b010);
        ovr_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("bounce_col_adv", kp_if.col, 3'b100);
        chk("bounce_no_valid", vcount, 0);
        chk("bounce_not_held", kp_if.key_held, 1'b0);

        // reset pulse while a key is held
        pressed = 12'h010;
        do_reset(3);
        repeat (30) @(negedge clk);
        chk("rst_mid_held", kp_if.key_held, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_outputs", {kp_if.col, kp_if.key_code, kp_if.key_valid, kp_if.key_held, kp_if.multi_key},
            {3'b001, 4'd0, 1'b0, 1'b0, 1'b0});
        vcount = 0;
        repeat (40) @(negedge clk);
        chk("rst_mid_revalid", vcount, 1);
        chk("rst_mid_code", kp_if.key_code, 4'd4);

        // random presses, double presses, row bounces and resets against the model
        pressed = '0;
        for (int k = 0; k < 400; k++) begin
            int act;
            act = $urandom_range(0, 9);
            if (act <= 5) begin
                pressed = '0;
                pressed[$urandom_range(0, N_KEYS-1)] = 1'b1;
            end else if (act == 6) begin
                pressed = '0;
                pressed[$urandom_range(0, N_KEYS-1)] = 1'b1;
                pressed[$urandom_range(0, N_KEYS-1)] = 1'b1;
            end else if (act == 7) begin
                pressed = '0;
            end else if (act == 8) begin
                ovr_row = 4'($urandom);
                ovr_en  = 1'b1;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                ovr_en  = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
